// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//
// Main controller for a multicycle MIPS datapath. A Moore FSM steps each
// instruction through FETCH/DECODE and its execute states, driving the
// shared memory, ALU and register-file muxes and enables. The ALU decoder
// sits downstream and receives alu_op; funct decoding stays there.
//
// Memory handshake: an access is requested by holding mem_req high. It
// completes in the cycle where mem_req and mem_ready are both high.
// mem_req stays high until that cycle, or until TIMEOUT consecutive
// unanswered cycles have passed. In that case the access is abandoned, the
// FSM returns to FETCH and the sticky mem_timeout flag is set.
//
// Optional feature: define MCU_BNE_EN to make opcode 5 (bne) legal.
// Without it, opcode 5 is reported as illegal like any other unknown opcode.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   opcode            IR[31:26], valid from DECODE onward
//   zero              ALU zero flag (used in BRANCH)
//   mem_ready         memory completes the current access this cycle
//   mem_req/mem_write memory request / write qualifier
//   iord              address mux (0 = PC, 1 = ALUOut)
//   ir_write          IR load enable
//   reg_dst           write register select (1 = rd, 0 = rt)
//   mem_to_reg        write data select (1 = MDR, 0 = ALUOut)
//   reg_write         register file write enable
//   alu_src_a         0 = PC, 1 = A
//   alu_src_b         00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
//   alu_op            00 = add, 01 = sub, 10 = funct
//   pc_src            00 = ALUResult, 01 = ALUOut, 10 = jump target
//   pc_en             PC load enable
//   illegal_op        one-cycle pulse in DECODE on an undecodable opcode
//   mem_timeout       sticky timeout flag, cleared only by rst
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int OPCODE_W = 6,
    parameter int TIMEOUT  = 16,
    parameter int CNT_W    = 5,
    parameter int OP_RTYPE = 0,
    parameter int OP_LW    = 35,
    parameter int OP_SW    = 43,
    parameter int OP_BEQ   = 4,
    parameter int OP_ADDI  = 8,
    parameter int OP_J     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_write,
    output logic                iord,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_src,
    output logic                pc_en,
    output logic                illegal_op,
    output logic                mem_timeout
);

    localparam logic [OPCODE_W-1:0] OPC_RTYPE = OPCODE_W'(OP_RTYPE);
    localparam logic [OPCODE_W-1:0] OPC_LW    = OPCODE_W'(OP_LW);
    localparam logic [OPCODE_W-1:0] OPC_SW    = OPCODE_W'(OP_SW);
    localparam logic [OPCODE_W-1:0] OPC_BEQ   = OPCODE_W'(OP_BEQ);
    localparam logic [OPCODE_W-1:0] OPC_ADDI  = OPCODE_W'(OP_ADDI);
    localparam logic [OPCODE_W-1:0] OPC_J     = OPCODE_W'(OP_J);
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             wait_state;
    logic             timeout_hit;

    // States that hold mem_req and wait for mem_ready.
    assign wait_state  = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    // TIMEOUT-th unanswered cycle; a mem_ready in the same cycle wins.
    assign timeout_hit = wait_state && !mem_ready && (cnt == CNT_LAST);

`ifdef MCU_BNE_EN
    localparam logic [OPCODE_W-1:0] OPC_BNE = OPCODE_W'(5);
    // The branch flavour is captured in DECODE so BRANCH does not depend
    // on the opcode input staying stable.
    logic bne_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            bne_flag <= 1'b0;
        end else if (state == S_DECODE) begin
            bne_flag <= (opcode == OPC_BNE);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            cnt         <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= next_state;
            if (timeout_hit) begin
                cnt         <= '0;
                mem_timeout <= 1'b1;
            end else if (wait_state && !mem_ready) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        illegal_op = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                if (mem_ready) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (opcode == OPC_LW || opcode == OPC_SW) begin
                    next_state = S_MEMADR;
                end else if (opcode == OPC_RTYPE) begin
                    next_state = S_EXEC;
                end else if (opcode == OPC_BEQ) begin
                    next_state = S_BRANCH;
`ifdef MCU_BNE_EN
                end else if (opcode == OPC_BNE) begin
                    next_state = S_BRANCH;
`endif
                end else if (opcode == OPC_ADDI) begin
                    next_state = S_ADDIEX;
                end else if (opcode == OPC_J) begin
                    next_state = S_JUMP;
                end else begin
                    illegal_op = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = (opcode == OPC_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    next_state = S_MEMWB;
                end else if (timeout_hit) begin
                    next_state = S_FETCH;
                end
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready || timeout_hit) begin
                    next_state = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
`ifdef MCU_BNE_EN
                pc_en      = bne_flag ? ~zero : zero;
`else
                pc_en      = zero;
`endif
                next_state = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_en      = 1'b1;
                next_state = S_FETCH;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase

        // During reset no strobe may fire and the muxes show FETCH settings,
        // whatever state the register happens to hold.
        if (rst) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            pc_en      = 1'b0;
            illegal_op = 1'b0;
            iord       = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b01;
            alu_op     = 2'b00;
            pc_src     = 2'b00;
        end
    end

endmodule
